irq_guard_multi: RTL and testbench
==================================

// Module: irq_guard_multi
// PURPOSE
//  Multi-region successor to the single-region IRQ/DMA guard: watches the CPU PC against N protected code regions.
//  Forces a registered core reset on:
//   - any interrupt or DMA activity inside a region;
//   - any non-atomic entry to or exit from a region.
//  Latches the violation cause, the offending region and a violation count for post-mortem firmware.
//  Sits beside the CPU core; `reset` feeds the core's reset combiner.
// PARAMETERS
//  NUM_REGIONS    2                        number of protected regions (1..8)
//  REGION_BASE    {16'h0100,16'h0010}      packed 16b base per region, region 0 in LSBs; even-aligned
//  REGION_SIZE    {16'h0040,16'h0010}      packed 16b byte size per region; even, nonzero; regions disjoint
//  RESET_HANDLER  16'h0000                 PC value that re-arms the guard
//  RESET_HOLD     4                        minimum cycles `reset` stays high after a violation (>=1)
//  DMA_CHECK      1                        1: dma_en inside a region is a violation; 0: ignored
//  ATOMIC_CHECK   1                        1: entry/exit rules enforced; 0: only irq/dma checks
// PORTS
//  clk         in   1   core clock
//  rst_n       in   1   synchronous, active-low reset
//  pc          in   16  current CPU program counter
//  irq         in   1   interrupt being taken this cycle
//  dma_en      in   1   DMA access active this cycle
//  reset       out  1   core reset request, registered
//  viol_cause  out  4   sticky cause: [0]IRQ [1]DMA [2]ENTRY [3]EXIT
//  viol_region out  3   index of region of most recent violation
//  viol_cnt    out  8   saturating violation count (saturates at 8'hFF)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge)
//   - state=KILL_WAIT, reset=1, viol_cause=0, viol_region=0, viol_cnt=0, hold_cnt=0, prev_pc=RESET_HANDLER.
//  Region decode (region r)
//   - in_r = base_r <= pc <= base_r+size_r-2.
//   - last_r = base_r+size_r-2.
//   - Arithmetic is 17-bit, so a region ending at 16'hFFFE does not wrap.
//  Violation terms (combinational, evaluated every cycle)
//   - IRQ:   irq & in_r.
//   - DMA:   DMA_CHECK & dma_en & in_r.
//   - ENTRY: ATOMIC_CHECK & in_r(pc) & !in_r(prev_pc) & pc!=base_r.
//   - EXIT:  ATOMIC_CHECK & in_r(prev_pc) & !in_r(pc) & prev_pc!=last_r.
//   - viol = OR of all terms over all regions.
//   - Lowest-index region with any term wins for viol_region.
//  prev_pc <= pc every cycle in all states.
//  State machine (registered, 3 states)
//   - RUN:
//       viol -> KILL_HOLD; reset<=1; hold_cnt<=RESET_HOLD-1; viol_cause|=terms; viol_region<=idx; viol_cnt+=1 (sat).
//       else stay; reset<=0.
//   - KILL_HOLD: reset=1.
//       hold_cnt!=0 -> hold_cnt-=1.
//       hold_cnt==0 -> KILL_WAIT.
//       Violations here are not counted and not logged.
//   - KILL_WAIT: reset=1.
//       pc==RESET_HANDLER & !viol -> RUN; reset<=0 on the same edge.
//       else stay.
//  Latency and hold
//   - A violation at edge t gives reset=1 from t+1.
//   - reset stays high for at least RESET_HOLD+1 cycles.
//  Sticky status
//   - viol_cause accumulates and is cleared only by rst_n.
//   - Multiple causes in one cycle all set.
//  Simultaneous events
//   - IRQ and EXIT in the same cycle: both bits set, count +1 only.
//   - Exiting region A directly into region B (both non-compliant): EXIT and ENTRY both set; viol_region = lower index.
//  Reset mid-operation
//   - rst_n low in any state forces the reset values above on that edge.
// STRUCTURE
//  Shared package irq_guard_pkg:
//   - state encoding RUN=2'd0, KILL_HOLD=2'd1, KILL_WAIT=2'd2;
//   - cause bit indices CAUSE_IRQ..CAUSE_EXIT;
//   - CNT_W=8.
//  Sub-module region_match (one per region, generate loop):
//   - inputs: pc, prev_pc; parameters BASE, SIZE;
//   - outputs: in_now, in_prev, at_base, prev_at_last.
//  Top level: priority encoder, FSM, hold counter, status registers.
// TESTING
//  1. Release rst_n with pc=16'h0000, irq=0 -> reset 1 during reset, 0 one cycle after release; viol_cnt=0.
//  2. Jump pc 0x0200->0x0010->...->0x001E->0x0202, no irq -> reset stays 0; viol_cause=0.
//  3. pc=0x0014 in region 0 and irq=1 for one cycle:
//     -> reset=1 next cycle, held 5 cycles, then KILL_WAIT;
//     -> viol_cause=4'b0001, viol_region=0, viol_cnt=1;
//     -> pc=0x0000 re-arms, reset=0 next cycle.
//  4. pc 0x0200->0x0120 (mid region 1) -> ENTRY: viol_cause[2]=1, viol_region=1.
//     Repeat with DMA_CHECK=0 and dma_en=1 inside region 1 -> no violation.
//  5. pc 0x0014->0x0104 (leave r0 early, enter r1 mid) -> viol_cause=4'b1100, viol_region=0, viol_cnt +1.
//  6. Force 256 violations -> viol_cnt saturates at 8'hFF.
//     Assert rst_n=0 mid KILL_HOLD -> all status cleared; state KILL_WAIT.

Source files
------------

// File: rtl/irq_guard_pkg.sv
// Shared definitions for the multi-region IRQ/DMA guard: FSM encoding,
// cause bit positions, field widths and a saturating counter helper.
package irq_guard_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_KILL_HOLD = 2'd1,
    ST_KILL_WAIT = 2'd2
  } state_e;

  localparam int CAUSE_IRQ   = 0;
  localparam int CAUSE_DMA   = 1;
  localparam int CAUSE_ENTRY = 2;
  localparam int CAUSE_EXIT  = 3;

  localparam int CAUSE_W  = 4;
  localparam int CNT_W    = 8;
  localparam int REGION_W = 3;
  localparam int PC_W     = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == {CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + CNT_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/region_match.sv
// Address decode for one protected region. The upper bound is computed in
// 17 bits so a region whose last instruction is 16'hFFFE does not wrap.
module region_match
  import irq_guard_pkg::*;
#(
  parameter logic [PC_W-1:0] BASE = 16'h0010,
  parameter logic [PC_W-1:0] SIZE = 16'h0010
) (
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] prev_pc,
  output logic            in_now,
  output logic            in_prev,
  output logic            at_base,
  output logic            prev_at_last
);

  localparam logic [PC_W:0] BASE_X = {1'b0, BASE};
  localparam logic [PC_W:0] LAST_X = {1'b0, BASE} + {1'b0, SIZE} - 17'd2;

  logic [PC_W:0] pc_x_s;
  logic [PC_W:0] prev_x_s;

  assign pc_x_s       = {1'b0, pc};
  assign prev_x_s     = {1'b0, prev_pc};
  assign in_now       = (pc_x_s >= BASE_X) && (pc_x_s <= LAST_X);
  assign in_prev      = (prev_x_s >= BASE_X) && (prev_x_s <= LAST_X);
  assign at_base      = (pc_x_s == BASE_X);
  assign prev_at_last = (prev_x_s == LAST_X);

endmodule

// File: rtl/irq_guard_multi.sv
// Multi-region IRQ/DMA guard. Watches the PC against NUM_REGIONS protected
// code regions and requests a registered core reset on interrupt/DMA activity
// inside a region or on a non-atomic entry/exit. Cause, region and a
// saturating count are latched for post-mortem firmware.
module irq_guard_multi
  import irq_guard_pkg::*;
#(
  parameter int                       NUM_REGIONS   = 2,
  parameter logic [16*NUM_REGIONS-1:0] REGION_BASE  = {16'h0100, 16'h0010},
  parameter logic [16*NUM_REGIONS-1:0] REGION_SIZE  = {16'h0040, 16'h0010},
  parameter logic [15:0]              RESET_HANDLER = 16'h0000,
  parameter int                       RESET_HOLD    = 4,
  parameter int                       DMA_CHECK     = 1,
  parameter int                       ATOMIC_CHECK  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PC_W-1:0]     pc,
  input  logic                irq,
  input  logic                dma_en,
  output logic                reset,
  output logic [CAUSE_W-1:0]  viol_cause,
  output logic [REGION_W-1:0] viol_region,
  output logic [CNT_W-1:0]    viol_cnt
);

  // Hold counter only needs to reach RESET_HOLD-1.
  localparam int   HOLD_W      = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic DMA_CHK_C   = (DMA_CHECK != 0);
  localparam logic ATOM_CHK_C  = (ATOMIC_CHECK != 0);

  state_e              state_r;
  state_e              next_state_s;
  logic                reset_r;
  logic                reset_next_s;
  logic [HOLD_W-1:0]   hold_cnt_r;
  logic [HOLD_W-1:0]   hold_next_s;
  logic [CAUSE_W-1:0]  viol_cause_r;
  logic [CAUSE_W-1:0]  cause_next_s;
  logic [REGION_W-1:0] viol_region_r;
  logic [REGION_W-1:0] region_next_s;
  logic [CNT_W-1:0]    viol_cnt_r;
  logic [CNT_W-1:0]    cnt_next_s;
  logic [PC_W-1:0]     prev_pc_r;

  logic [NUM_REGIONS-1:0] in_now_s;
  logic [NUM_REGIONS-1:0] in_prev_s;
  logic [NUM_REGIONS-1:0] at_base_s;
  logic [NUM_REGIONS-1:0] prev_at_last_s;
  logic [CAUSE_W-1:0]     region_terms_s [NUM_REGIONS];
  logic [CAUSE_W-1:0]     terms_s;
  logic [REGION_W-1:0]    viol_idx_s;
  logic                   viol_s;

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region
    region_match #(
      .BASE (REGION_BASE[16*g +: 16]),
      .SIZE (REGION_SIZE[16*g +: 16])
    ) u_match (
      .pc           (pc),
      .prev_pc      (prev_pc_r),
      .in_now       (in_now_s[g]),
      .in_prev      (in_prev_s[g]),
      .at_base      (at_base_s[g]),
      .prev_at_last (prev_at_last_s[g])
    );

    assign region_terms_s[g][CAUSE_IRQ]   = irq & in_now_s[g];
    assign region_terms_s[g][CAUSE_DMA]   = DMA_CHK_C & dma_en & in_now_s[g];
    assign region_terms_s[g][CAUSE_ENTRY] = ATOM_CHK_C & in_now_s[g] & ~in_prev_s[g] & ~at_base_s[g];
    assign region_terms_s[g][CAUSE_EXIT]  = ATOM_CHK_C & in_prev_s[g] & ~in_now_s[g] & ~prev_at_last_s[g];
  end

  // Merge per-region terms; scan high to low so the lowest index wins.
  always_comb begin
    terms_s    = 4'd0;
    viol_idx_s = 3'd0;
    for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
      terms_s = terms_s | region_terms_s[r];
      if (|region_terms_s[r]) begin
        viol_idx_s = REGION_W'(r);
      end else begin
        viol_idx_s = viol_idx_s;
      end
    end
    viol_s = |terms_s;
  end

  // Next-state and next-value logic for the FSM, hold counter and status.
  always_comb begin
    next_state_s  = state_r;
    reset_next_s  = reset_r;
    hold_next_s   = hold_cnt_r;
    cause_next_s  = viol_cause_r;
    region_next_s = viol_region_r;
    cnt_next_s    = viol_cnt_r;
    case (state_r)
      ST_RUN: begin
        if (viol_s) begin
          next_state_s  = ST_KILL_HOLD;
          reset_next_s  = 1'b1;
          hold_next_s   = HOLD_W'(RESET_HOLD - 1);
          cause_next_s  = viol_cause_r | terms_s;
          region_next_s = viol_idx_s;
          cnt_next_s    = sat_inc(viol_cnt_r);
        end else begin
          reset_next_s  = 1'b0;
        end
      end
      ST_KILL_HOLD: begin
        reset_next_s = 1'b1;
        if (hold_cnt_r != HOLD_W'(0)) begin
          hold_next_s = hold_cnt_r - HOLD_W'(1);
        end else begin
          next_state_s = ST_KILL_WAIT;
        end
      end
      ST_KILL_WAIT: begin
        if ((pc == RESET_HANDLER) && !viol_s) begin
          next_state_s = ST_RUN;
          reset_next_s = 1'b0;
        end else begin
          reset_next_s = 1'b1;
        end
      end
      default: begin
        next_state_s = ST_KILL_WAIT;
        reset_next_s = 1'b1;
      end
    endcase
  end

  // State, status and PC history registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_KILL_WAIT;
      reset_r       <= 1'b1;
      hold_cnt_r    <= HOLD_W'(0);
      viol_cause_r  <= 4'd0;
      viol_region_r <= 3'd0;
      viol_cnt_r    <= 8'd0;
      prev_pc_r     <= RESET_HANDLER;
    end else begin
      state_r       <= next_state_s;
      reset_r       <= reset_next_s;
      hold_cnt_r    <= hold_next_s;
      viol_cause_r  <= cause_next_s;
      viol_region_r <= region_next_s;
      viol_cnt_r    <= cnt_next_s;
      prev_pc_r     <= pc;
    end
  end

  assign reset       = reset_r;
  assign viol_cause  = viol_cause_r;
  assign viol_region = viol_region_r;
  assign viol_cnt    = viol_cnt_r;

endmodule

// File: tb/tb_irq_guard_multi.sv
// Bench for irq_guard_multi: two instances (DMA checking on and off) driven
// by the same directed and random PC/irq/dma stream, compared every cycle
// against a behavioural model built from the region/violation rules.
module tb_irq_guard_multi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pc;
  logic        irq;
  logic        dma_en;

  logic        reset_a, reset_b;
  logic [3:0]  cause_a, cause_b;
  logic [2:0]  region_a, region_b;
  logic [7:0]  cnt_a, cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: region table and per-instance guard state.
  int  rb [2] = '{32'h0010, 32'h0100};
  int  rs [2] = '{32'h0010, 32'h0040};
  int  m_mode [2];   // 0 run, 1 holding, 2 waiting for handler
  int  m_hold [2];
  int  m_cnt  [2];
  int  m_reg  [2];
  int  m_prev [2];
  bit  m_rst  [2];
  bit [3:0] m_cause [2];

  int pick [16] = '{32'h0000, 32'h0000, 32'h000E, 32'h0010, 32'h0012, 32'h0018,
                    32'h001E, 32'h0020, 32'h00FE, 32'h0100, 32'h0102, 32'h0120,
                    32'h013E, 32'h0140, 32'h0200, 32'hFFFE};

  always #5 clk = ~clk;

  irq_guard_multi #(.DMA_CHECK(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .pc(pc), .irq(irq), .dma_en(dma_en),
    .reset(reset_a), .viol_cause(cause_a), .viol_region(region_a), .viol_cnt(cnt_a)
  );

  irq_guard_multi #(.DMA_CHECK(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .pc(pc), .irq(irq), .dma_en(dma_en),
    .reset(reset_b), .viol_cause(cause_b), .viol_region(region_b), .viol_cnt(cnt_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit in_reg(input int addr, input int r);
    return (addr >= rb[r]) && (addr <= rb[r] + rs[r] - 2);
  endfunction

  // Apply the guard rules for one clock edge to model instance m.
  task automatic model_step(input int m, input bit dmachk);
    bit [3:0] t;
    bit [3:0] tr;
    bit       inn, inp, v;
    int       idx;
    int       p;
    if (!rst_n) begin
      m_mode[m] = 2; m_rst[m] = 1'b1; m_cause[m] = 4'd0; m_reg[m] = 0;
      m_cnt[m] = 0;  m_hold[m] = 0;   m_prev[m] = 0;
      return;
    end
    p = int'(pc);
    t = 4'd0;
    idx = -1;
    for (int r = 0; r < 2; r++) begin
      inn   = in_reg(p, r);
      inp   = in_reg(m_prev[m], r);
      tr[0] = irq && inn;
      tr[1] = dmachk && dma_en && inn;
      tr[2] = inn && !inp && (p != rb[r]);
      tr[3] = inp && !inn && (m_prev[m] != rb[r] + rs[r] - 2);
      t = t | tr;
      if (tr != 4'd0 && idx < 0) idx = r;
    end
    v = (t != 4'd0);
    if (m_mode[m] == 0) begin
      if (v) begin
        m_mode[m]  = 1;
        m_rst[m]   = 1'b1;
        m_hold[m]  = 3;
        m_cause[m] = m_cause[m] | t;
        m_reg[m]   = idx;
        m_cnt[m]   = (m_cnt[m] < 255) ? m_cnt[m] + 1 : 255;
      end else begin
        m_rst[m] = 1'b0;
      end
    end else if (m_mode[m] == 1) begin
      m_rst[m] = 1'b1;
      if (m_hold[m] > 0) m_hold[m]--;
      else m_mode[m] = 2;
    end else begin
      if (p == 0 && !v) begin
        m_mode[m] = 0;
        m_rst[m]  = 1'b0;
      end else begin
        m_rst[m]  = 1'b1;
      end
    end
    m_prev[m] = p;
  endtask

  // One clock: advance both models at the edge, compare #1 later.
  task automatic tick();
    @(posedge clk);
    model_step(0, 1'b1);
    model_step(1, 1'b0);
    #1;
    check_val("a_reset",  reset_a,  m_rst[0]);
    check_val("a_cause",  cause_a,  m_cause[0]);
    check_val("a_region", region_a, m_reg[0]);
    check_val("a_cnt",    cnt_a,    m_cnt[0]);
    check_val("b_reset",  reset_b,  m_rst[1]);
    check_val("b_cause",  cause_b,  m_cause[1]);
    check_val("b_region", region_b, m_reg[1]);
    check_val("b_cnt",    cnt_b,    m_cnt[1]);
  endtask

  task automatic drive(input logic [15:0] p, input logic i, input logic d);
    pc = p; irq = i; dma_en = d;
    tick();
  endtask

  // Sit outside all regions long enough for any hold to expire, then re-arm.
  task automatic recover();
    for (int k = 0; k < 6; k++) drive(16'h0200, 1'b0, 1'b0);
    drive(16'h0000, 1'b0, 1'b0);
    drive(16'h0000, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; pc = 16'h0000; irq = 1'b0; dma_en = 1'b0;

    // Reset and release
    tick();
    tick();
    check_val("rst_reset_high", reset_a, 1'b1);
    check_val("rst_cnt_zero", cnt_a, 8'd0);
    rst_n = 1'b1;
    tick();
    check_val("release_reset_low", reset_a, 1'b0);

    // Compliant traversal of region 0
    drive(16'h0200, 1'b0, 1'b0);
    for (int a = 16'h0010; a <= 16'h001E; a += 2) drive(16'(a), 1'b0, 1'b0);
    drive(16'h0202, 1'b0, 1'b0);
    check_val("walk_reset", reset_a, 1'b0);
    check_val("walk_cause", cause_a, 4'd0);

    // IRQ inside region 0, reset held RESET_HOLD+1 cycles
    drive(16'h0010, 1'b0, 1'b0);
    drive(16'h0012, 1'b0, 1'b0);
    drive(16'h0014, 1'b1, 1'b0);
    check_val("irq_cause", cause_a, 4'b0001);
    check_val("irq_region", region_a, 3'd0);
    check_val("irq_cnt", cnt_a, 8'd1);
    for (int k = 0; k < 4; k++) begin
      drive(16'h0200, 1'b0, 1'b0);
      check_val("irq_hold", reset_a, 1'b1);
    end
    drive(16'h0000, 1'b0, 1'b0);
    check_val("irq_rearm", reset_a, 1'b0);

    // Mid-region entry into region 1
    drive(16'h0200, 1'b0, 1'b0);
    drive(16'h0120, 1'b0, 1'b0);
    check_val("entry_bit", cause_a[2], 1'b1);
    check_val("entry_region", region_a, 3'd1);
    recover();

    // DMA inside region 1: only the DMA-checking instance reacts
    drive(16'h0100, 1'b0, 1'b0);
    drive(16'h0104, 1'b0, 1'b1);
    check_val("dma_a_reset", reset_a, 1'b1);
    check_val("dma_b_reset", reset_b, 1'b0);
    drive(16'h013E, 1'b0, 1'b0);
    drive(16'h0200, 1'b0, 1'b0);
    drive(16'h0200, 1'b0, 1'b0);
    drive(16'h0200, 1'b0, 1'b0);
    drive(16'h0000, 1'b0, 1'b0);
    drive(16'h0000, 1'b0, 1'b0);

    // Early exit from region 0 straight into the middle of region 1
    drive(16'h0010, 1'b0, 1'b0);
    drive(16'h0014, 1'b0, 1'b0);
    drive(16'h0104, 1'b0, 1'b0);
    check_val("xfer_cause_hi", cause_a[3:2], 2'b11);
    check_val("xfer_region", region_a, 3'd0);
    recover();

    // Saturate the violation counter
    for (int n = 0; n < 260; n++) begin
      drive(16'h0014, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) drive(16'h0200, 1'b0, 1'b0);
      drive(16'h0000, 1'b0, 1'b0);
    end
    check_val("sat_cnt", cnt_a, 8'hFF);

    // rst_n in the middle of the hold window
    drive(16'h0014, 1'b1, 1'b0);
    drive(16'h0200, 1'b0, 1'b0);
    rst_n = 1'b0;
    drive(16'h0200, 1'b0, 1'b0);
    rst_n = 1'b1;
    check_val("midrst_cnt", cnt_a, 8'd0);
    check_val("midrst_cause", cause_a, 4'd0);
    drive(16'h0200, 1'b0, 1'b0);
    check_val("midrst_wait", reset_a, 1'b1);
    drive(16'h0000, 1'b0, 1'b0);
    check_val("midrst_rearm", reset_a, 1'b0);

    // Random traffic: jumps, sequential steps, sparse irq/dma/rst_n
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 1) == 0) pc = 16'(pick[$urandom_range(0, 15)]);
      else pc = pc + 16'd2;
      irq    = ($urandom_range(0, 7) == 0);
      dma_en = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
